// File: rtl/posit_pkg.sv
// Shared widths, helper functions and record types for the posit add datapath.
package posit_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Mantissa width including the hidden bit, as produced by extraction.
    function automatic int unsigned m_width(input int unsigned n, input int unsigned es);
        return n - es + 3;
    endfunction

    // Signed scale width: regime (rs+1 bits) shifted by es, plus headroom.
    function automatic int unsigned sw_width(input int unsigned rs, input int unsigned es);
        return rs + es + 2;
    endfunction

    // Aligned width: mantissa plus guard and sticky positions.
    function automatic int unsigned w_width(input int unsigned n, input int unsigned es);
        return m_width(n, es) + 2;
    endfunction

    localparam int unsigned POSIT_N  = 8;
    localparam int unsigned POSIT_ES = 3;
    localparam int unsigned POSIT_RS = clog2(POSIT_N);
    localparam int unsigned POSIT_M  = m_width(POSIT_N, POSIT_ES);
    localparam int unsigned POSIT_SW = sw_width(POSIT_RS, POSIT_ES);
    localparam int unsigned POSIT_W  = w_width(POSIT_N, POSIT_ES);

    typedef struct packed {
        logic                       sign;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_M-1:0]         mantissa;
        logic                       zero;
        logic                       nar;
    } posit_operand_t;

    typedef struct packed {
        logic                       sign;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_M-1:0]         mantissa;
        logic                       guard;
        logic                       sticky;
        logic                       zero;
        logic                       nar;
    } posit_result_t;

endpackage

// File: rtl/posit_add_core_if.sv
// Operand/result bundle with valid/ready handshakes for posit_add_core.
interface posit_add_core_if #(
    parameter int unsigned N  = posit_pkg::POSIT_N,
    parameter int unsigned ES = posit_pkg::POSIT_ES,
    parameter int unsigned RS = posit_pkg::clog2(N)
);
    localparam int unsigned M  = posit_pkg::m_width(N, ES);
    localparam int unsigned SW = posit_pkg::sw_width(RS, ES);

    logic                 in_valid;
    logic                 in_ready;
    logic                 A_Sign;
    logic                 B_Sign;
    logic signed [RS:0]   A_RegimeValue;
    logic signed [RS:0]   B_RegimeValue;
    logic [ES-1:0]        A_Exponent;
    logic [ES-1:0]        B_Exponent;
    logic [M-1:0]         A_Mantissa;
    logic [M-1:0]         B_Mantissa;
    logic                 A_Zero;
    logic                 B_Zero;
    logic                 A_NaR;
    logic                 B_NaR;

    logic                 out_valid;
    logic                 out_ready;
    logic                 Sign;
    logic signed [SW-1:0] Scale;
    logic [M-1:0]         Mantissa;
    logic                 Guard;
    logic                 Sticky;
    logic                 Zero;
    logic                 NaR;

    modport master (
        output in_valid, A_Sign, B_Sign, A_RegimeValue, B_RegimeValue,
               A_Exponent, B_Exponent, A_Mantissa, B_Mantissa,
               A_Zero, B_Zero, A_NaR, B_NaR, out_ready,
        input  in_ready, out_valid, Sign, Scale, Mantissa, Guard, Sticky, Zero, NaR
    );

    modport slave (
        input  in_valid, A_Sign, B_Sign, A_RegimeValue, B_RegimeValue,
               A_Exponent, B_Exponent, A_Mantissa, B_Mantissa,
               A_Zero, B_Zero, A_NaR, B_NaR, out_ready,
        output in_ready, out_valid, Sign, Scale, Mantissa, Guard, Sticky, Zero, NaR
    );

endinterface

// File: rtl/posit_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module posit_lzc
    import posit_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned CW    = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/posit_add_core.sv
// Three-stage posit magnitude add: compare/swap, align, add/normalize.
// Operand/result records are sized by the posit_pkg configuration, so the
// N/ES/RS parameters here must match POSIT_N/POSIT_ES/POSIT_RS.
module posit_add_core
    import posit_pkg::*;
#(
    parameter int unsigned N  = POSIT_N,
    parameter int unsigned ES = POSIT_ES,
    parameter int unsigned RS = clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    posit_add_core_if.slave  bus
);
    localparam int unsigned M  = m_width(N, ES);
    localparam int unsigned SW = sw_width(RS, ES);
    localparam int unsigned W  = w_width(N, ES);
    localparam int unsigned DW = SW + 1;
    localparam int unsigned LW = clog2(W + 2);

    function automatic logic signed [SW-1:0] to_scale(input logic signed [RS:0] k,
                                                      input logic [ES-1:0]      e);
        logic signed [SW-1:0] ks;
        ks = SW'(k);
        return (ks <<< ES) + SW'(e);
    endfunction

    logic adv;

    posit_operand_t       op_a, op_b;
    logic                 a_is_l;
    logic                 l_sign;
    logic signed [SW-1:0] l_scale, s_scale;
    logic [M-1:0]         l_mant, s_mant;
    logic [DW-1:0]        diff_c;

    logic                 s1_valid, s1_nar, s1_sign, s1_sub;
    logic signed [SW-1:0] s1_scale;
    logic [M-1:0]         s1_mant_l, s1_mant_s;
    logic [DW-1:0]        s1_diff;

    logic [W-1:0]         ext_s, aligned_c;

    logic                 s2_valid, s2_nar, s2_sign, s2_sub;
    logic signed [SW-1:0] s2_scale;
    logic [M-1:0]         s2_mant_l;
    logic [W-1:0]         s2_aligned;

    logic [W:0]           sum, norm;
    logic [LW-1:0]        lz;
    posit_result_t        res_c;

    logic                 s3_valid;
    posit_result_t        s3_res;

    assign adv          = bus.out_ready | ~s3_valid;
    assign bus.in_ready = adv;

    // S1: unpack operands, pick the larger magnitude and the scale gap.
    always_comb begin
        op_a.sign     = bus.A_Sign;
        op_a.scale    = to_scale(bus.A_RegimeValue, bus.A_Exponent);
        op_a.mantissa = bus.A_Zero ? '0 : bus.A_Mantissa;
        op_a.zero     = bus.A_Zero;
        op_a.nar      = bus.A_NaR;
        op_b.sign     = bus.B_Sign;
        op_b.scale    = to_scale(bus.B_RegimeValue, bus.B_Exponent);
        op_b.mantissa = bus.B_Zero ? '0 : bus.B_Mantissa;
        op_b.zero     = bus.B_Zero;
        op_b.nar      = bus.B_NaR;

        if (op_b.zero)                        a_is_l = 1'b1;
        else if (op_a.zero)                   a_is_l = 1'b0;
        else if (op_a.scale != op_b.scale)    a_is_l = ($signed(op_a.scale) > $signed(op_b.scale));
        else                                  a_is_l = (op_a.mantissa >= op_b.mantissa);

        l_sign  = a_is_l ? op_a.sign     : op_b.sign;
        l_scale = a_is_l ? op_a.scale    : op_b.scale;
        l_mant  = a_is_l ? op_a.mantissa : op_b.mantissa;
        s_scale = a_is_l ? op_b.scale    : op_a.scale;
        s_mant  = a_is_l ? op_b.mantissa : op_a.mantissa;
        // A zero smaller operand contributes nothing, so its scale is ignored.
        diff_c  = (a_is_l ? op_b.zero : op_a.zero) ? '0 : (DW'(l_scale) - DW'(s_scale));
    end

    // S2: shift the smaller mantissa right, collapsing lost bits into sticky.
    always_comb begin
        ext_s     = {s1_mant_s, 2'b00};
        aligned_c = '0;
        if (s1_diff >= DW'(W)) begin
            aligned_c[0] = |s1_mant_s;
        end else begin
            aligned_c    = ext_s >> s1_diff;
            aligned_c[0] = aligned_c[0] | (|(ext_s & ~({W{1'b1}} << s1_diff)));
        end
    end

    posit_lzc #(.WIDTH(W + 1), .CW(LW)) u_lzc (
        .value (sum),
        .count (lz)
    );

    // S3: add/subtract and normalize. The lzc spans the carry bit too, so
    // shifting by lz and keeping sum[W:1] covers both the carry-out case
    // (lz=0, sum[0] folds into sticky) and renormalization; scale moves by 1-lz.
    always_comb begin
        sum   = s2_sub ? ({1'b0, s2_mant_l, 2'b00} - {1'b0, s2_aligned})
                       : ({1'b0, s2_mant_l, 2'b00} + {1'b0, s2_aligned});
        norm  = sum << lz;
        res_c = '0;
        if (s2_nar) begin
            res_c.nar = 1'b1;
        end else if (sum == '0) begin
            res_c.zero = 1'b1;
        end else begin
            res_c.sign     = s2_sign;
            res_c.scale    = s2_scale + SW'(1) - SW'(lz);
            res_c.mantissa = norm[W:3];
            res_c.guard    = norm[2];
            res_c.sticky   = |norm[1:0];
        end
    end

    // Pipeline registers: all stages advance together whenever the output can move.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_nar     <= 1'b0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_scale   <= '0;
            s1_mant_l  <= '0;
            s1_mant_s  <= '0;
            s1_diff    <= '0;
            s2_valid   <= 1'b0;
            s2_nar     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_sub     <= 1'b0;
            s2_scale   <= '0;
            s2_mant_l  <= '0;
            s2_aligned <= '0;
            s3_valid   <= 1'b0;
            s3_res     <= '0;
        end else if (adv) begin
            s1_valid   <= bus.in_valid;
            s1_nar     <= op_a.nar | op_b.nar;
            s1_sign    <= l_sign;
            s1_sub     <= op_a.sign ^ op_b.sign;
            s1_scale   <= l_scale;
            s1_mant_l  <= l_mant;
            s1_mant_s  <= s_mant;
            s1_diff    <= diff_c;
            s2_valid   <= s1_valid;
            s2_nar     <= s1_nar;
            s2_sign    <= s1_sign;
            s2_sub     <= s1_sub;
            s2_scale   <= s1_scale;
            s2_mant_l  <= s1_mant_l;
            s2_aligned <= aligned_c;
            s3_valid   <= s2_valid;
            s3_res     <= res_c;
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.Sign      = s3_res.sign;
    assign bus.Scale     = s3_res.scale;
    assign bus.Mantissa  = s3_res.mantissa;
    assign bus.Guard     = s3_res.guard;
    assign bus.Sticky    = s3_res.sticky;
    assign bus.Zero      = s3_res.zero;
    assign bus.NaR       = s3_res.nar;

endmodule

// File: tb/tb_posit_add_core.sv
// Self-checking bench for posit_add_core with a reference model and scoreboard.
module tb_posit_add_core;
    localparam int unsigned N  = 8;
    localparam int unsigned ES = 3;
    localparam int unsigned RS = 3;
    localparam int          W  = 10;

    typedef struct {
        logic sign;
        int   k;
        int   e;
        int   mant;
        logic zero;
        logic nar;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    posit_add_core_if #(.N(N), .ES(ES), .RS(RS)) bus ();

    posit_add_core #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned n_out = 0;
    logic [20:0] exp_q[$];
    string       phase = "reset";
    logic        rnd_active = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] pack(input logic sign, input int scale, input int mant,
                                         input logic g, input logic s, input logic z, input logic n);
        return {sign, 8'(scale), 8'(mant), g, s, z, n};
    endfunction

    function automatic logic [20:0] observed();
        return {bus.Sign, bus.Scale, bus.Mantissa, bus.Guard, bus.Sticky, bus.Zero, bus.NaR};
    endfunction

    function automatic op_t mk(input logic sign, input int k, input int e, input int mant);
        op_t o;
        o.sign = sign; o.k = k; o.e = e; o.mant = mant; o.zero = 1'b0; o.nar = 1'b0;
        return o;
    endfunction

    // Reference: value = mant * 2^(scale-7); align/add/normalize with integer arithmetic.
    function automatic logic [20:0] model(input op_t a, input op_t b);
        int sa, sb, ma, mb, sl, ml, ms, diff, al, sum, p, v, sc;
        logic a_l, sgn, sub, drop;
        if (a.nar || b.nar) return pack(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        sa = a.k * (1 << ES) + a.e;
        sb = b.k * (1 << ES) + b.e;
        ma = a.zero ? 0 : a.mant;
        mb = b.zero ? 0 : b.mant;
        if (b.zero)        a_l = 1'b1;
        else if (a.zero)   a_l = 1'b0;
        else if (sa != sb) a_l = (sa > sb);
        else               a_l = (ma >= mb);
        sl   = a_l ? sa : sb;
        ml   = a_l ? ma : mb;
        ms   = a_l ? mb : ma;
        diff = a_l ? sa - sb : sb - sa;
        sgn  = a_l ? a.sign : b.sign;
        sub  = a.sign ^ b.sign;
        if (ms == 0) al = 0;
        else if (diff >= W) al = 1;
        else begin
            al = (ms * 4) / (1 << diff);
            if ((ms * 4) % (1 << diff) != 0) al = al | 1;
        end
        sum = sub ? ml * 4 - al : ml * 4 + al;
        if (sum == 0) return pack(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        p = 0;
        while ((sum >> (p + 1)) != 0) p++;
        if (p == W) begin
            drop = sum[0];
            v    = sum >> 1;
            sc   = sl + 1;
        end else begin
            drop = 1'b0;
            v    = sum << (W - 1 - p);
            sc   = sl - (W - 1 - p);
        end
        return pack(sgn, sc, v >> 2, v[1], v[0] | drop, 1'b0, 1'b0);
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.sign = 1'($urandom_range(1));
        o.k    = int'($urandom_range(13)) - 7;
        o.e    = int'($urandom_range(7));
        o.mant = 128 + int'($urandom_range(127));
        o.zero = ($urandom_range(15) == 0);
        o.nar  = ($urandom_range(31) == 0);
        return o;
    endfunction

    // Present one operand pair, wait (bounded) for acceptance, queue its expectation.
    task automatic drive(input op_t a, input op_t b, input logic [20:0] want);
        int unsigned t;
        bus.A_Sign = a.sign; bus.A_RegimeValue = 4'(a.k); bus.A_Exponent = 3'(a.e);
        bus.A_Mantissa = 8'(a.mant); bus.A_Zero = a.zero; bus.A_NaR = a.nar;
        bus.B_Sign = b.sign; bus.B_RegimeValue = 4'(b.k); bus.B_Exponent = 3'(b.e);
        bus.B_Mantissa = 8'(b.mant); bus.B_Zero = b.zero; bus.B_NaR = b.nar;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back(want);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single transaction on an idle pipe: check value (via monitor) and latency.
    task automatic directed(input string name, input op_t a, input op_t b, input logic [20:0] want);
        int unsigned lat;
        phase = name;
        drive(a, b, want);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 10);
        check({name, "_latency"}, lat, 3);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every valid output is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check({phase, "_unexpected"}, bus.out_valid, 0);
            end else begin
                check(phase, observed(), exp_q[0]);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t a, b;
        int unsigned n0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A_Sign = 1'b0; bus.A_RegimeValue = '0; bus.A_Exponent = '0; bus.A_Mantissa = '0;
        bus.A_Zero = 1'b0; bus.A_NaR = 1'b0;
        bus.B_Sign = 1'b0; bus.B_RegimeValue = '0; bus.B_Exponent = '0; bus.B_Mantissa = '0;
        bus.B_Zero = 1'b0; bus.B_NaR = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus.out_valid, observed()}, 22'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        directed("one_plus_one", mk(0, 0, 0, 'h80), mk(0, 0, 0, 'h80),
                 pack(0, 1, 'h80, 0, 0, 0, 0));
        directed("one_minus_one", mk(0, 0, 0, 'h80), mk(1, 0, 0, 'h80),
                 pack(0, 0, 0, 0, 0, 1, 0));
        directed("large_diff", mk(0, 1, 2, 'h80), mk(0, 0, 0, 'hFF),
                 pack(0, 10, 'h80, 0, 1, 0, 0));
        directed("sub_renorm", mk(0, 0, 0, 'h80), mk(1, -1, 7, 'hFF),
                 pack(0, -8, 'h80, 0, 0, 0, 0));
        a = mk(0, 1, 1, 'h90); a.nar = 1'b1;
        directed("nar", a, mk(1, 0, 3, 'hC0), pack(0, 0, 0, 0, 0, 0, 1));
        a = mk(0, 3, 0, 'hEE); a.zero = 1'b1;
        directed("zero_pass", a, mk(1, 2, 5, 'hA5), pack(1, 21, 'hA5, 0, 0, 0, 0));
        b = mk(0, 0, 0, 'h80); b.zero = 1'b1;
        directed("both_zero", a, b, pack(0, 0, 0, 0, 0, 1, 0));

        phase = "random";
        rnd_active = 1'b1;
        fork
            while (rnd_active) begin
                @(posedge clk);
                #1;
                bus.out_ready = ($urandom_range(3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            a = rand_op();
            b = rand_op();
            if ($urandom_range(1) == 1) begin
                b.k = a.k;
                b.e = ($urandom_range(1) == 1) ? a.e : int'($urandom_range(7));
                b.sign = ~a.sign;
            end
            drive(a, b, model(a, b));
            if ($urandom_range(7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_active = 1'b0;
        wait fork;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("random_drain", exp_q.size(), 0);
        @(posedge clk);
        #1;

        phase = "backpressure";
        bus.out_ready = 1'b0;
        n0 = n_out;
        fork
            for (int i = 0; i < 5; i++) begin
                op_t x, y;
                x = mk(1'($urandom_range(1)), int'($urandom_range(6)) - 3, i, 128 + 20 * i);
                y = mk(1'($urandom_range(1)), int'($urandom_range(6)) - 3, 7 - i, 250 - 9 * i);
                drive(x, y, model(x, y));
            end
        join_none
        repeat (8) @(negedge clk);
        check("bp_accepted", exp_q.size(), 3);
        check("bp_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait fork;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("bp_drain", exp_q.size(), 0);
        check("bp_emitted", n_out - n0, 5);
        @(posedge clk);
        #1;

        phase = "reset_flight";
        drive(mk(0, 0, 1, 'h88), mk(0, 0, 2, 'h99), pack(0, 0, 0, 0, 0, 0, 0));
        drive(mk(0, 1, 0, 'hA0), mk(1, 0, 0, 'hB0), pack(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("reset_flush", bus.out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_idle", bus.out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_add_core.md
# posit_add_core

Pipelined posit magnitude-add stage directly downstream of `Data_Extraction`. It takes the extracted fields of two posit operands (sign, regime value, exponent, hidden-bit mantissa), aligns them by total scale and adds or subtracts them. It produces a normalized sign/scale/mantissa result with guard and sticky bits for the downstream rounding/packing stage. Three register stages, valid/ready handshake on both sides, full backpressure.

## Interface
- `N`, 8: posit width.
- `ES`, 3: exponent field width.
- `RS`, log2(N): regime value width minus 1, so `RegimeValue` is RS+1 bits signed.
- Derived: M = N-ES+3 (mantissa width, matches extraction output); SW = RS+ES+2 (signed scale width); W = M+2 (aligned width: mantissa, guard, sticky).
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept.
- `A_Sign`, `B_Sign`  in  1  operand signs.
- `A_RegimeValue`, `B_RegimeValue`  in  RS+1 signed  regime k.
- `A_Exponent`, `B_Exponent`  in  ES  exponent field.
- `A_Mantissa`, `B_Mantissa`  in  M  mantissa, hidden 1 at MSB.
- `A_Zero`, `B_Zero`, `A_NaR`, `B_NaR`  in  1  special-value flags from the upstream wrapper.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `Sign`  out  1  result sign.
- `Scale`  out  SW signed  result scale, k*2^ES + e.
- `Mantissa`  out  M  normalized mantissa, MSB = 1 unless `Zero`.
- `Guard`, `Sticky`  out  1  rounding bits.
- `Zero`, `NaR`  out  1  result special flags.

## Operation
- Scale per operand: (RegimeValue <<< ES) + Exponent, sign-extended to SW.
- **S1 (compare/swap):**
  - Larger magnitude becomes L. Order by scale, then by mantissa on equal scale; tie keeps A as L.
  - diff = scale_L - scale_S.
  - Effective op = subtract when signs differ.
  - A zero operand is treated as the smaller operand with mantissa 0.
- **S2 (align):**
  - S mantissa is extended to W bits and right-shifted by min(diff, W).
  - Every bit shifted out ORs into the W LSB (sticky).
  - diff ≥ W means S contributes sticky only, and only if its mantissa is nonzero.
- **S3 (add/normalize):**
  - W+1-bit sum or difference of L·00 and the aligned S.
  - On carry out: shift right 1, fold the dropped bit into sticky, scale+1.
  - Otherwise: left-shift by the leading-zero count from `posit_lzc`, and subtract that count from the scale.
  - Output fields: Mantissa = top M bits, Guard = next bit, Sticky = OR of the rest.
- **Result sign:** sign of L. An exact zero result forces Sign=0, Zero=1, Scale=0, Mantissa=0.
- **Specials:**
  - Either NaR: NaR=1, all other outputs 0.
  - Both zero: Zero=1.
  - One zero: the other operand passes through unchanged, with Guard=Sticky=0.
- **Scale arithmetic:** SW bits is sufficient; no saturation in this block. The pack stage clamps to maxpos/minpos.

## Timing
- Latency exactly 3 cycles from the accepting edge (in_valid & in_ready) to out_valid, when unstalled.
- Throughput 1 per cycle.
- Advance condition: adv = out_ready | ~out_valid. All three stages shift together on adv; in_ready = adv (combinational from out_ready).
- Bubbles: invalid stages still shift, which removes bubbles only at the output end. Holding 3 in-flight results with out_ready low deasserts in_ready.
- While out_valid & ~out_ready: all outputs stay stable.
- Reset values (next edge): all stage valids 0, out_valid=0. Sign, Scale, Mantissa, Guard, Sticky, Zero and NaR are all 0. Data registers are also cleared.
- Reset mid-flight discards all in-flight results; none are emitted after reset.
- in_valid asserted with in_ready low: the operands are not captured; upstream must hold them.

## Structure
- `posit_pkg` holds:
  - the log2 function;
  - width functions for M, SW and W;
  - a typedef for the unpacked operand struct {sign, scale, mantissa, zero, nar};
  - a typedef for the result struct.
- One sub-module: `posit_lzc`, a parameterized leading-zero counter over W+1 bits. It is combinational and used in S3.
- Stage registers are inline in `posit_add_core`.

## Test plan
All scenarios use N=8, ES=3, M=8, out_ready=1 unless stated.
- **1.0 + 1.0:** A=B=(k0, e0, 0x80, sign 0) -> 3 cycles later Scale=1, Mantissa=0x80, Sign 0, G=S=0.
- **1.0 + (-1.0):** -> Zero=1, Sign=0, Scale=0, Mantissa=0.
- **Large diff:** A scale 10, mantissa 0x80; B scale 0, mantissa 0xFF -> Scale=10, Mantissa=0x80, Guard=0, Sticky=1.
- **Subtract with renormalize:** A scale 0, mantissa 0x80; B scale -1, mantissa 0xFF, B negative -> Scale=-8, Mantissa=0x80, G=S=0 (exact result 2^-8).
- **NaR operand:** A_NaR=1 -> NaR=1 and all other outputs 0; a zero operand -> the other operand passes through.
- **Backpressure, then reset:**
  - Hold out_ready=0 and stream 5 pairs -> in_ready falls after 3 accepts; outputs hold stable; all 5 results then emerge in order with no loss or duplication once out_ready=1.
  - Assert reset with 2 results in flight -> out_valid=0 at the next edge and nothing further is emitted.
